osnt_rx_stamp_extractor: RTL and testbench

- Receive-side counterpart of the free-running stamp counter: passively taps an ingress AXI-Stream bus and extracts the 64-bit TX timestamp that the generator embedded in each packet.
- Samples the local STAMP_COUNTER at start-of-packet and emits one-way latency (arrival minus embedded stamp) per packet on a small AXI-Stream result port.
- Sits in the monitor path beside the packet filter, sharing the clock domain of the stamp counter.

---
 rtl/osnt_stamp_pkg.sv | 16 +
 rtl/osnt_stamp_result_fifo.sv | 58 +++++
 rtl/osnt_rx_stamp_extractor.sv | 182 ++++++++++++++++++
 tb/tb_osnt_rx_stamp_extractor.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/osnt_stamp_pkg.sv
// Shared constants and types for the receive-side stamp extractor.
package osnt_stamp_pkg;

    localparam int          STAMP_BYTES     = 8;
    localparam int          STAMP_TS_WIDTH  = STAMP_BYTES * 8;
    localparam logic [31:0] STAMP_SIGNATURE = 32'h4F53_4E54;

    typedef logic [STAMP_TS_WIDTH-1:0] stamp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HUNT = 2'd1,
        ST_DONE = 2'd2
    } ext_state_t;

endpackage

// File: rtl/osnt_stamp_result_fifo.sv
// Synchronous result FIFO; a pop in the same cycle frees a slot for a push into a full FIFO.
module osnt_stamp_result_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push,
    output logic             full,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    input  logic             pop_ready
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign pop_valid = (count != '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign do_pop    = pop_valid & pop_ready;
    assign do_push   = push & (~full | do_pop);
    // Head is forced to zero when empty so the output reads 0 out of reset.
    assign pop_data  = pop_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/osnt_rx_stamp_extractor.sv
// Passive AXI-Stream tap: extracts the embedded TX stamp and reports one-way latency per packet.
// Define OSNT_STAMP_SIGNATURE_CHECK_EN to also require the 32-bit signature after the stamp.
//
// state | meaning
// IDLE  | waiting for start of packet
// HUNT  | counting beats toward the stamp beat
// DONE  | stamp seen, waiting for TLAST
module osnt_rx_stamp_extractor
    import osnt_stamp_pkg::*;
#(
    parameter int TIMESTAMP_WIDTH     = 64,
    parameter int C_S_AXIS_DATA_WIDTH = 256,
    parameter int STAMP_BYTE_OFFSET   = 32,
    parameter int RESULT_FIFO_DEPTH   = 4
) (
    input  logic                             ACLK,
    input  logic                             ARESET,
    input  logic [TIMESTAMP_WIDTH-1:0]       STAMP_COUNTER,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] S_AXIS_TKEEP,
    input  logic                             S_AXIS_TVALID,
    input  logic                             S_AXIS_TREADY,
    input  logic                             S_AXIS_TLAST,
    output logic [TIMESTAMP_WIDTH-1:0]       M_LAT_TDATA,
    output logic                             M_LAT_TVALID,
    input  logic                             M_LAT_TREADY,
    output logic [31:0]                      DROP_COUNT,
    output logic [31:0]                      SHORT_COUNT
);

    localparam int          W          = C_S_AXIS_DATA_WIDTH / 8;
    localparam int          SB         = STAMP_BYTE_OFFSET / W;
    localparam int          L          = STAMP_BYTE_OFFSET % W;
    localparam bit          SB_IS_ZERO = (SB == 0);
    localparam logic [15:0] SB_CNT     = 16'(SB);

    if (L + STAMP_BYTES > W) begin : g_err_lane
        $error("stamp does not fit in one beat");
    end
    if ((STAMP_BYTE_OFFSET % 8) != 0) begin : g_err_align
        $error("stamp offset must be 8-byte aligned");
    end
    if (TIMESTAMP_WIDTH != STAMP_TS_WIDTH) begin : g_err_width
        $error("timestamp width must match the embedded stamp width");
    end
    if (SB > 65535) begin : g_err_beat
        $error("stamp beat index exceeds beat counter range");
    end
    if (RESULT_FIFO_DEPTH < 2 || (RESULT_FIFO_DEPTH & (RESULT_FIFO_DEPTH - 1)) != 0) begin : g_err_depth
        $error("result FIFO depth must be a power of two, at least 2");
    end

    ext_state_t                 state;
    ext_state_t                 state_nxt;
    logic                       beat_acc;
    logic [15:0]                beat_cnt;
    logic [15:0]                beat_cnt_nxt;
    logic [TIMESTAMP_WIDTH-1:0] arrival_q;
    stamp_t                     stamp_q;
    logic                       stamp_ok_q;
    stamp_t                     beat_stamp;
    logic                       beat_stamp_ok;
    logic                       capture;
    logic                       resolve;
    logic [TIMESTAMP_WIDTH-1:0] cur_arrival;
    stamp_t                     cur_stamp;
    logic                       cur_ok;
    logic                       fifo_full;
    logic                       lat_pop;
    logic                       unused_tap;

    assign beat_acc   = S_AXIS_TVALID & S_AXIS_TREADY;
    assign beat_stamp = S_AXIS_TDATA[L*8 +: STAMP_TS_WIDTH];
    assign lat_pop    = M_LAT_TVALID & M_LAT_TREADY;
    assign unused_tap = ^{S_AXIS_TDATA, S_AXIS_TKEEP};

`ifdef OSNT_STAMP_SIGNATURE_CHECK_EN
    if (L + STAMP_BYTES + 4 > W) begin : g_err_sig
        $error("stamp signature does not fit in one beat");
    end
    logic [31:0] beat_sig;
    assign beat_sig      = S_AXIS_TDATA[(L+STAMP_BYTES)*8 +: 32];
    assign beat_stamp_ok = (&S_AXIS_TKEEP[L +: STAMP_BYTES+4]) && (beat_sig == STAMP_SIGNATURE);
`else
    assign beat_stamp_ok = &S_AXIS_TKEEP[L +: STAMP_BYTES];
`endif

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (beat_acc) begin
                if (S_AXIS_TLAST)    state_nxt = ST_IDLE;
                else if (SB_IS_ZERO) state_nxt = ST_DONE;
                else                 state_nxt = ST_HUNT;
            end
            ST_HUNT: if (beat_acc) begin
                if (S_AXIS_TLAST) state_nxt = ST_IDLE;
                else if (capture) state_nxt = ST_DONE;
            end
            ST_DONE: if (beat_acc && S_AXIS_TLAST) begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A packet resolving in the same beat as its capture uses the live beat, not the registers.
    always_comb begin
        capture      = 1'b0;
        resolve      = 1'b0;
        beat_cnt_nxt = beat_cnt;
        cur_arrival  = arrival_q;
        cur_stamp    = stamp_q;
        cur_ok       = stamp_ok_q;
        case (state)
            ST_IDLE: if (beat_acc) begin
                cur_arrival  = STAMP_COUNTER;
                beat_cnt_nxt = '0;
                capture      = SB_IS_ZERO;
                resolve      = S_AXIS_TLAST;
                cur_ok       = 1'b0;
            end
            ST_HUNT: if (beat_acc) begin
                beat_cnt_nxt = beat_cnt + 16'd1;
                capture      = (beat_cnt_nxt == SB_CNT);
                resolve      = S_AXIS_TLAST;
                cur_ok       = 1'b0;
            end
            ST_DONE: resolve = beat_acc & S_AXIS_TLAST;
            default: ;
        endcase
        if (capture) begin
            cur_stamp = beat_stamp;
            cur_ok    = beat_stamp_ok;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            beat_cnt    <= '0;
            arrival_q   <= '0;
            stamp_q     <= '0;
            stamp_ok_q  <= 1'b0;
            DROP_COUNT  <= '0;
            SHORT_COUNT <= '0;
        end else begin
            beat_cnt   <= beat_cnt_nxt;
            arrival_q  <= cur_arrival;
            stamp_q    <= cur_stamp;
            stamp_ok_q <= cur_ok;
            if (resolve && !cur_ok && SHORT_COUNT != 32'hFFFF_FFFF) begin
                SHORT_COUNT <= SHORT_COUNT + 32'd1;
            end
            if (resolve && cur_ok && fifo_full && !lat_pop && DROP_COUNT != 32'hFFFF_FFFF) begin
                DROP_COUNT <= DROP_COUNT + 32'd1;
            end
        end
    end

    osnt_stamp_result_fifo #(
        .WIDTH (TIMESTAMP_WIDTH),
        .DEPTH (RESULT_FIFO_DEPTH)
    ) u_result_fifo (
        .clk       (ACLK),
        .reset     (ARESET),
        .push_data (cur_arrival - cur_stamp),
        .push      (resolve & cur_ok),
        .full      (fifo_full),
        .pop_data  (M_LAT_TDATA),
        .pop_valid (M_LAT_TVALID),
        .pop_ready (M_LAT_TREADY)
    );

endmodule

// File: tb/tb_osnt_rx_stamp_extractor.sv
// Bench for osnt_rx_stamp_extractor: vector table plus back-pressure sequences, latency scoreboard.
module tb_osnt_rx_stamp_extractor;
    import osnt_stamp_pkg::*;

    localparam int DW    = 256;
    localparam int KW    = DW / 8;
    localparam int DEPTH = 4;

    logic            ACLK = 1'b0;
    logic            ARESET = 1'b1;
    logic [63:0]     STAMP_COUNTER;
    logic [DW-1:0]   S_AXIS_TDATA;
    logic [KW-1:0]   S_AXIS_TKEEP;
    logic            S_AXIS_TVALID;
    logic            S_AXIS_TREADY;
    logic            S_AXIS_TLAST;
    logic [63:0]     M_LAT_TDATA;
    logic            M_LAT_TVALID;
    logic            M_LAT_TREADY;
    logic [31:0]     DROP_COUNT;
    logic [31:0]     SHORT_COUNT;

    always #5 ACLK = ~ACLK;

    osnt_rx_stamp_extractor dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .STAMP_COUNTER (STAMP_COUNTER),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TKEEP  (S_AXIS_TKEEP),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .M_LAT_TDATA   (M_LAT_TDATA),
        .M_LAT_TVALID  (M_LAT_TVALID),
        .M_LAT_TREADY  (M_LAT_TREADY),
        .DROP_COUNT    (DROP_COUNT),
        .SHORT_COUNT   (SHORT_COUNT)
    );

    typedef struct {
        logic [63:0] arr;
        logic [63:0] stamp;
        int          nbeats;
        logic [7:0]  kst;
        logic [31:0] sig;
        int          stall;
        logic [63:0] lat;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    int          exp_short = 0;
    int          exp_drop = 0;
    logic [63:0] exp_q [$];
    vec_t        vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Output monitor: sampled mid-cycle, after the inputs for the coming edge are settled.
    always begin
        @(negedge ACLK);
        #2;
        if (ARESET === 1'b0 && M_LAT_TVALID === 1'b1 && M_LAT_TREADY === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got %0h expected none", M_LAT_TDATA);
            end else begin
                check("latency", M_LAT_TDATA, exp_q.pop_front());
            end
        end
    end

    task automatic send_pkt(input logic [63:0] arr, input logic [63:0] stamp, input int nbeats,
                            input logic [7:0] kst, input logic [31:0] sig, input int stall,
                            input logic [63:0] lat, input bit pulse_rdy);
        bit good;
        bit timing;
        good = (nbeats >= 2) && (kst == 8'hFF);
`ifdef OSNT_STAMP_SIGNATURE_CHECK_EN
        good = good && (sig == STAMP_SIGNATURE);
`endif
        timing = (exp_q.size() == 0) && (M_LAT_TREADY == 1'b1);
        for (int b = 0; b < nbeats; b++) begin
            if (b == 1) begin
                for (int s = 0; s < stall; s++) begin
                    @(negedge ACLK);
                    S_AXIS_TVALID = 1'b1;
                    S_AXIS_TREADY = 1'b0;
                    S_AXIS_TLAST  = 1'b1;
                    S_AXIS_TDATA  = rnd_data();
                    S_AXIS_TKEEP  = '1;
                    STAMP_COUNTER = {$urandom, $urandom};
                    @(posedge ACLK);
                end
            end
            @(negedge ACLK);
            S_AXIS_TVALID = 1'b1;
            S_AXIS_TREADY = 1'b1;
            S_AXIS_TLAST  = (b == nbeats - 1);
            S_AXIS_TDATA  = rnd_data();
            S_AXIS_TKEEP  = '1;
            STAMP_COUNTER = (b == 0) ? arr : {$urandom, $urandom};
            if (b == 1) begin
                S_AXIS_TDATA[63:0]  = stamp;
                S_AXIS_TDATA[95:64] = sig;
                S_AXIS_TKEEP[7:0]   = kst;
            end
            if (S_AXIS_TLAST && pulse_rdy) M_LAT_TREADY = 1'b1;
            if (S_AXIS_TLAST && timing) begin
                #2;
                check("valid_before_last", {63'd0, M_LAT_TVALID}, 64'd0);
            end
            @(posedge ACLK);
        end
        #1;
        if (!good) exp_short++;
        else if (exp_q.size() < DEPTH) exp_q.push_back(lat);
        else exp_drop++;
        @(negedge ACLK);
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
        S_AXIS_TREADY = 1'($urandom_range(1));
        STAMP_COUNTER = {$urandom, $urandom};
        if (pulse_rdy) M_LAT_TREADY = 1'b0;
        if (timing) begin
            #2;
            check("valid_after_last", {63'd0, M_LAT_TVALID}, {63'd0, good});
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge ACLK);
        repeat (2) @(posedge ACLK);
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        vecs[0] = '{64'd1000, 64'd400, 3, 8'hFF, STAMP_SIGNATURE, 0, 64'd600};
        vecs[1] = '{64'h5, 64'hFFFF_FFFF_FFFF_FFFE, 2, 8'hFF, STAMP_SIGNATURE, 0, 64'd7};
        vecs[2] = '{64'd1000, 64'd400, 1, 8'hFF, STAMP_SIGNATURE, 0, 64'd0};
        vecs[3] = '{64'd1000, 64'd400, 3, 8'h0F, STAMP_SIGNATURE, 0, 64'd0};
        vecs[4] = '{64'h1_2345_6789, 64'h1_0000_0000, 4, 8'hFF, STAMP_SIGNATURE, 10, 64'h2345_6789};
        vecs[5] = '{64'h0, 64'h1, 2, 8'hFF, STAMP_SIGNATURE, 0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[6] = '{64'd77, 64'd77, 5, 8'hFF, STAMP_SIGNATURE, 3, 64'd0};

        STAMP_COUNTER = '0;
        S_AXIS_TDATA  = '0;
        S_AXIS_TKEEP  = '0;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TREADY = 1'b0;
        S_AXIS_TLAST  = 1'b0;
        M_LAT_TREADY  = 1'b1;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        #2;
        check("rst_tvalid", {63'd0, M_LAT_TVALID}, 64'd0);
        check("rst_tdata", M_LAT_TDATA, 64'd0);
        check("rst_drop", {32'd0, DROP_COUNT}, 64'd0);
        check("rst_short", {32'd0, SHORT_COUNT}, 64'd0);
        @(negedge ACLK);
        ARESET = 1'b0;

        for (int i = 0; i < 7; i++) begin
            send_pkt(vecs[i].arr, vecs[i].stamp, vecs[i].nbeats, vecs[i].kst, vecs[i].sig,
                     vecs[i].stall, vecs[i].lat, 1'b0);
        end
        drain("table_drain");
        check("short_after_table", {32'd0, SHORT_COUNT}, 64'(exp_short));
        check("short_is_two", 64'(exp_short), 64'd2);
        check("drop_after_table", {32'd0, DROP_COUNT}, 64'(exp_drop));

        // Back-pressure: six results into a four-deep FIFO.
        @(negedge ACLK);
        M_LAT_TREADY = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send_pkt(64'd2000 + 64'(i * 7) + 64'd10 + 64'(i), 64'd2000 + 64'(i * 7), 2, 8'hFF,
                     STAMP_SIGNATURE, 0, 64'd10 + 64'(i), 1'b0);
        end
        check("drop_backpressure", {32'd0, DROP_COUNT}, 64'(exp_drop));
        check("drop_is_two", 64'(exp_drop), 64'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            #2;
            check("held_valid", {63'd0, M_LAT_TVALID}, 64'd1);
            check("held_data", M_LAT_TDATA, 64'd10);
        end

        // Push into a full FIFO in the same cycle as a pop: must not drop.
        send_pkt(64'd5016, 64'd5000, 2, 8'hFF, STAMP_SIGNATURE, 0, 64'd16, 1'b1);
        check("drop_push_pop_full", {32'd0, DROP_COUNT}, 64'(exp_drop));
        @(negedge ACLK);
        M_LAT_TREADY = 1'b1;
        drain("backpressure_drain");

`ifdef OSNT_STAMP_SIGNATURE_CHECK_EN
        send_pkt(64'd900, 64'd100, 3, 8'hFF, STAMP_SIGNATURE, 0, 64'd800, 1'b0);
        send_pkt(64'd900, 64'd100, 3, 8'hFF, 32'h0000_0000, 0, 64'd0, 1'b0);
        drain("signature_drain");
        check("short_after_signature", {32'd0, SHORT_COUNT}, 64'(exp_short));
`endif

        // Random good packets with free-running ready.
        for (int i = 0; i < 8; i++) begin
            logic [63:0] a;
            logic [63:0] s;
            a = {$urandom, $urandom};
            s = {$urandom, $urandom};
            send_pkt(a, s, 2 + i % 3, 8'hFF, STAMP_SIGNATURE, i % 2, a - s, 1'b0);
        end
        drain("random_drain");
        check("short_final", {32'd0, SHORT_COUNT}, 64'(exp_short));
        check("drop_final", {32'd0, DROP_COUNT}, 64'(exp_drop));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
